// File: rtl/matrix_3x3_gen.sv
// Builds a sliding 3x3 pixel window from a raster stream using two line buffers.
// Column triples are fetched one cycle after accept; the window shifts one cycle later.
module matrix_3x3_gen #(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_data,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33
);
    localparam int              LB_AW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [ADDR_W:0] COL_MAX = (ADDR_W + 1)'(IMG_WIDTH);

    logic              vsync_d_reg;
    logic              href_d_reg;
    logic [1:0]        vsync_dly_reg;
    logic [1:0]        href_dly_reg;
    logic [ADDR_W:0]   col_cnt_reg;
    logic [1:0]        line_cnt_reg;
    logic              frame_active_reg;

    logic              vsync_rise;
    logic              href_rise;
    logic              href_fall;
    logic              accept;
    logic [LB_AW-1:0]  lb_addr;

    logic              valid_s1_reg;
    logic [DATA_W-1:0] row3_reg;
    logic [1:0]        line_s1_reg;
    logic [LB_AW-1:0]  addr_s1_reg;
    logic [DATA_W-1:0] rd1_reg;
    logic [DATA_W-1:0] rd0_reg;

    logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
    logic [DATA_W-1:0] col_in  [3];

    assign vsync_rise = per_frame_vsync & ~vsync_d_reg;
    assign href_rise  = per_frame_href & ~href_d_reg;
    assign href_fall  = ~per_frame_href & href_d_reg;
    assign accept     = per_frame_href & per_frame_clken & (col_cnt_reg < COL_MAX);
    assign lb_addr    = col_cnt_reg[LB_AW-1:0];

    // Line counting only restarts after a vsync rise, so a reset mid-frame
    // keeps the upper rows masked until a fresh frame begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d_reg      <= 1'b0;
            href_d_reg       <= 1'b0;
            vsync_dly_reg    <= '0;
            href_dly_reg     <= '0;
            col_cnt_reg      <= '0;
            line_cnt_reg     <= '0;
            frame_active_reg <= 1'b0;
        end else begin
            vsync_d_reg   <= per_frame_vsync;
            href_d_reg    <= per_frame_href;
            vsync_dly_reg <= {vsync_dly_reg[0], per_frame_vsync};
            href_dly_reg  <= {href_dly_reg[0], per_frame_href};
            if (href_fall) begin
                col_cnt_reg <= '0;
            end else if (accept) begin
                col_cnt_reg <= col_cnt_reg + 1'b1;
            end
            if (vsync_rise) begin
                line_cnt_reg     <= '0;
                frame_active_reg <= 1'b1;
            end else if (href_fall && frame_active_reg && line_cnt_reg != 2'd2) begin
                line_cnt_reg <= line_cnt_reg + 2'd1;
            end
        end
    end

    // lb0 is refilled from lb1's registered read one cycle later, which keeps
    // both buffers as single-port-per-side block RAMs with read-before-write.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd1_reg          <= lb1_mem[lb_addr];
            rd0_reg          <= lb0_mem[lb_addr];
            lb1_mem[lb_addr] <= per_img_data;
        end
        if (valid_s1_reg) begin
            lb0_mem[addr_s1_reg] <= rd1_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1_reg <= 1'b0;
            row3_reg     <= '0;
            line_s1_reg  <= '0;
            addr_s1_reg  <= '0;
        end else begin
            valid_s1_reg <= accept;
            if (accept) begin
                row3_reg    <= per_img_data;
                line_s1_reg <= line_cnt_reg;
                addr_s1_reg <= lb_addr;
            end
        end
    end

    always_comb begin
        col_in[0] = (line_s1_reg >= 2'd2) ? rd0_reg : '0;
        col_in[1] = (line_s1_reg >= 2'd1) ? rd1_reg : '0;
        col_in[2] = row3_reg;
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            logic [DATA_W-1:0] w_reg [3];
            always_ff @(posedge clk) begin
                if (rst || href_rise) begin
                    w_reg[0] <= '0;
                    w_reg[1] <= '0;
                    w_reg[2] <= '0;
                end else if (valid_s1_reg) begin
                    w_reg[0] <= w_reg[1];
                    w_reg[1] <= w_reg[2];
                    w_reg[2] <= col_in[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            matrix_frame_clken <= 1'b0;
        end else begin
            matrix_frame_clken <= valid_s1_reg;
        end
    end

    assign matrix_frame_vsync = vsync_dly_reg[1];
    assign matrix_frame_href  = href_dly_reg[1];
    assign matrix_p11 = g_row[0].w_reg[0];
    assign matrix_p12 = g_row[0].w_reg[1];
    assign matrix_p13 = g_row[0].w_reg[2];
    assign matrix_p21 = g_row[1].w_reg[0];
    assign matrix_p22 = g_row[1].w_reg[1];
    assign matrix_p23 = g_row[1].w_reg[2];
    assign matrix_p31 = g_row[2].w_reg[0];
    assign matrix_p32 = g_row[2].w_reg[1];
    assign matrix_p33 = g_row[2].w_reg[2];

endmodule
